// File: rtl/vga_pkg.sv
// Shared definitions for the TinyVGA PMOD receive path: 640x480 timing,
// PMOD pin map and the lock state machine encoding.
package vga_pkg;

    // Default 640x480@60 timing as seen by the receiver's own counters
    localparam int H_TOTAL_640  = 800;
    localparam int V_TOTAL_640  = 525;
    localparam int H_ACTIVE_640 = 640;
    localparam int V_ACTIVE_640 = 480;
    localparam int H_START_640  = 143;
    localparam int V_START_640  = 34;

    // PMOD pin positions: {hsync, B0, G0, R0, vsync, B1, G1, R1}
    localparam int PMOD_HS = 7;
    localparam int PMOD_B0 = 6;
    localparam int PMOD_G0 = 5;
    localparam int PMOD_R0 = 4;
    localparam int PMOD_VS = 3;
    localparam int PMOD_B1 = 2;
    localparam int PMOD_G1 = 1;
    localparam int PMOD_R1 = 0;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Polarity correction and leading-edge pulse for one sync line.
// sync_lead is high for the first cycle the sync is asserted.
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic sync_lead
);

    logic sync_a;
    logic sync_a_d;

    assign sync_a = ACTIVE_LOW ? ~sync_in : sync_in;

    // One-cycle delayed copy of the asserted level
    always_ff @(posedge clk) begin
        if (!rst_n) sync_a_d <= 1'b0;
        else        sync_a_d <= sync_a;
    end

    assign sync_lead = sync_a & ~sync_a_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// TinyVGA PMOD receiver: recovers line/frame timing from the sync pins,
// locks onto the expected timing and regenerates de, pixel coordinates
// and 2-bit RGB with a fixed 2-clock pin-to-output latency.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_TOTAL         = H_TOTAL_640,
    parameter int V_TOTAL         = V_TOTAL_640,
    parameter int H_ACTIVE        = H_ACTIVE_640,
    parameter int V_ACTIVE        = V_ACTIVE_640,
    parameter int H_START         = H_START_640,
    parameter int V_START         = V_START_640,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pmod_in,
    output logic [1:0]  r,
    output logic [1:0]  g,
    output logic [1:0]  b,
    output logic        de,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_meas,
    output logic [9:0]  frame_meas,
    output logic [7:0]  err_cnt
);

    // Counters are compared one bit wider so +1 and 2*TOTAL never wrap
    localparam logic [11:0] H_TOT_L = 12'(H_TOTAL);
    localparam logic [11:0] H_TMO_L = 12'(2 * H_TOTAL);
    localparam logic [11:0] H_BEG_L = 12'(H_START);
    localparam logic [11:0] H_END_L = 12'(H_START + H_ACTIVE);
    localparam logic [10:0] V_TOT_L = 11'(V_TOTAL);
    localparam logic [10:0] V_TMO_L = 11'(2 * V_TOTAL);
    localparam logic [10:0] V_BEG_L = 11'(V_START);
    localparam logic [10:0] V_END_L = 11'(V_START + V_ACTIVE);

    logic [7:0]  in_q;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        vs_pend;
    logic        bad, bad_nxt;
    logic        err_inc;
    lock_state_t state, state_nxt;

    logic [1:0]  sync_raw, sync_lead;
    logic        hs_lead, vs_lead, frame_b;
    logic [11:0] h_ext, h_len;
    logic [10:0] v_ext, v_len;
    logic        line_bad, frame_bad, timeout;
    logic        lock_nxt, de_nxt;

    // Pins are registered once; everything downstream works on in_q
    always_ff @(posedge clk) begin
        if (!rst_n) in_q <= '0;
        else        in_q <= pmod_in;
    end

    // Bit 1 carries hsync, bit 0 carries vsync
    assign sync_raw = {in_q[PMOD_HS], in_q[PMOD_VS]};

    for (genvar i = 0; i < 2; i++) begin : g_sync
        sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_sync (
            .clk       (clk),
            .rst_n     (rst_n),
            .sync_in   (sync_raw[i]),
            .sync_lead (sync_lead[i])
        );
    end

    assign hs_lead   = sync_lead[1];
    assign vs_lead   = sync_lead[0];
    // A frame ends on the first hsync lead at or after a vsync lead
    assign frame_b   = hs_lead & (vs_pend | vs_lead);

    assign h_ext     = {1'b0, h_cnt};
    assign h_len     = h_ext + 12'd1;
    assign v_ext     = {1'b0, v_cnt};
    assign v_len     = v_ext + 11'd1;
    assign line_bad  = hs_lead & (h_len != H_TOT_L);
    assign frame_bad = frame_b & (v_len != V_TOT_L);
    // With v_cnt saturating at 1023 the vertical limit only bites for small V_TOTAL
    assign timeout   = (h_ext >= H_TMO_L) | (v_ext >= V_TMO_L);

    // Horizontal counter and line length capture (saturating readback)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            line_meas <= '0;
        end else if (hs_lead) begin
            h_cnt     <= '0;
            line_meas <= h_len[11] ? 11'h7FF : h_len[10:0];
        end else if (h_cnt != 11'h7FF) begin
            h_cnt     <= h_cnt + 11'd1;
        end
    end

    // Vertical counter, pending-vsync flag and frame length capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_cnt      <= '0;
            vs_pend    <= 1'b0;
            frame_meas <= '0;
        end else begin
            if (frame_b) begin
                v_cnt      <= '0;
                vs_pend    <= 1'b0;
                frame_meas <= v_len[10] ? 10'h3FF : v_len[9:0];
            end else begin
                if (vs_lead) vs_pend <= 1'b1;
                if (hs_lead && v_cnt != 10'h3FF) v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SEARCH;
            bad     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bad     <= bad_nxt;
            if (err_inc) err_cnt <= sat_inc8(err_cnt);
        end
    end

    // Lock FSM next state: one clean frame in ACQUIRE earns LOCKED
    always_comb begin
        state_nxt = state;
        bad_nxt   = bad;
        err_inc   = 1'b0;
        case (state)
            SEARCH: begin
                if (frame_b) begin
                    state_nxt = ACQUIRE;
                    bad_nxt   = 1'b0;
                end
            end
            ACQUIRE: begin
                if (frame_b) begin
                    if (!bad && !line_bad && !frame_bad) state_nxt = LOCKED;
                    else                                 bad_nxt   = 1'b0;
                end else if (line_bad) begin
                    bad_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad) begin
                    state_nxt = SEARCH;
                    err_inc   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
        // A dead link overrides everything else
        if (timeout) begin
            state_nxt = SEARCH;
            err_inc   = (state == LOCKED);
        end
    end

    // de is built from the next state so it falls together with locked
    assign lock_nxt = (state_nxt == LOCKED);
    assign de_nxt   = lock_nxt
                    & (h_ext >= H_BEG_L) & (h_ext < H_END_L)
                    & (v_ext >= V_BEG_L) & (v_ext < V_END_L);

    // Registered pixel outputs, all gated to zero outside the active area
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked      <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            locked      <= lock_nxt;
            de          <= de_nxt;
            frame_start <= de_nxt & (h_ext == H_BEG_L) & (v_ext == V_BEG_L);
            pix_x       <= de_nxt ? 10'(h_ext - H_BEG_L) : 10'd0;
            pix_y       <= de_nxt ? 10'(v_ext - V_BEG_L) : 10'd0;
            r           <= de_nxt ? {in_q[PMOD_R1], in_q[PMOD_R0]} : 2'd0;
            g           <= de_nxt ? {in_q[PMOD_G1], in_q[PMOD_G0]} : 2'd0;
            b           <= de_nxt ? {in_q[PMOD_B1], in_q[PMOD_B0]} : 2'd0;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder. A scaled-down hvsync-style source
// (40x20 total, 24x12 active) keeps whole frames short while exercising
// the same lock, blanking and error paths as 640x480.
module tb_vga_sync_decoder;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HA  = 24;
    localparam int VA  = 12;
    localparam int HS0 = 26;   // hsync asserted for hpos 26..31
    localparam int HS1 = 32;
    localparam int VS0 = 14;   // vsync asserted for lines 14..15
    localparam int VS1 = 16;
    // Lead seen at in_q hpos 26 -> h_cnt 0 at hpos 27 -> hpos 0 is h_cnt 13
    localparam int HST = 13;
    // v_cnt clears after line 14's lead -> line 15 is 0 -> line 0 is 5
    localparam int VST = 5;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pmod_in;
    logic [1:0]  r, g, b;
    logic        de, frame_start, locked;
    logic [9:0]  pix_x, pix_y, frame_meas;
    logic [10:0] line_meas;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    // Source position currently on the pins, and fault-injection controls
    int src_f, src_v, src_h;
    int short_f = 4, short_l = 5;
    int kill_f = 6, kill_l0 = 3, kill_l1 = 6;

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_START(HST), .V_START(VST), .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pmod_in(pmod_in),
        .r(r), .g(g), .b(b), .de(de), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .locked(locked),
        .line_meas(line_meas), .frame_meas(frame_meas), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_pins();
        logic       hs, vs;
        logic [1:0] cr, cg, cb;
        hs = (src_h >= HS0) && (src_h < HS1) &&
             !(src_f == kill_f && src_v >= kill_l0 && src_v <= kill_l1);
        vs = (src_v >= VS0) && (src_v < VS1);
        cr = 2'd0; cg = 2'd0; cb = 2'd0;
        if (src_h < HA && src_v < VA) begin
            cr = 2'(src_h + 3);
            cg = 2'(src_v);
            cb = 2'(src_h + src_v + 1);
        end
        pmod_in = {~hs, cb[0], cg[0], cr[0], ~vs, cb[1], cg[1], cr[1]};
    endtask

    // Pixel source: advances one position just after every rising edge
    initial begin
        src_f = 0; src_v = 0; src_h = 0;
        drive_pins();
        forever begin
            @(posedge clk); #1;
            if (src_h == HT - 1 || (src_h == HT - 2 && src_f == short_f && src_v == short_l)) begin
                src_h = 0;
                if (src_v == VT - 1) begin src_v = 0; src_f++; end
                else src_v++;
            end else begin
                src_h++;
            end
            drive_pins();
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge where the pins show (f, v, h)
    task automatic wait_at(input int f, input int v, input int h);
        int  n;
        logic hit;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            hit = (src_f == f && src_v == v && src_h == h);
        end while (!hit && n < 3000);
        chk($sformatf("reach_f%0d_v%0d_h%0d", f, v, h), 32'(hit), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_r"}, 32'(r), 0);
        chk({tag, "_g"}, 32'(g), 0);
        chk({tag, "_b"}, 32'(b), 0);
        chk({tag, "_de"}, 32'(de), 0);
        chk({tag, "_px"}, 32'(pix_x), 0);
        chk({tag, "_py"}, 32'(pix_y), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_lock"}, 32'(locked), 0);
        chk({tag, "_lmeas"}, 32'(line_meas), 0);
        chk({tag, "_fmeas"}, 32'(frame_meas), 0);
        chk({tag, "_err"}, 32'(err_cnt), 0);
    endtask

    initial begin
        int de_n, fs_n;
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First boundary (frame 0) only acquires; lock at frame 1's boundary
        wait_at(0, 14, 28); chk("acq_lock", 32'(locked), 0);
        wait_at(1, 14, 27); chk("pre_lock", 32'(locked), 0);
        wait_at(1, 14, 28); chk("lock1", 32'(locked), 1);
        chk("lmeas1", 32'(line_meas), HT);
        chk("fmeas1", 32'(frame_meas), VT);
        chk("err1", 32'(err_cnt), 0);

        // Outputs lag the pins by two clocks
        wait_at(2, 0, 1);  chk("blank_de", 32'(de), 0); chk("blank_fs", 32'(frame_start), 0);
        wait_at(2, 0, 2);
        chk("p00_de", 32'(de), 1); chk("p00_fs", 32'(frame_start), 1);
        chk("p00_px", 32'(pix_x), 0); chk("p00_py", 32'(pix_y), 0);
        chk("p00_r", 32'(r), 3); chk("p00_g", 32'(g), 0); chk("p00_b", 32'(b), 1);
        wait_at(2, 0, 3);
        chk("p10_fs", 32'(frame_start), 0); chk("p10_px", 32'(pix_x), 1);
        chk("p10_r", 32'(r), 0); chk("p10_b", 32'(b), 2);
        wait_at(2, 3, 1);
        chk("hbl_de", 32'(de), 0); chk("hbl_px", 32'(pix_x), 0); chk("hbl_py", 32'(pix_y), 0);
        wait_at(2, 3, 2);
        chk("p03_de", 32'(de), 1); chk("p03_px", 32'(pix_x), 0); chk("p03_py", 32'(pix_y), 3);
        wait_at(2, 11, 25);
        chk("plast_de", 32'(de), 1); chk("plast_px", 32'(pix_x), HA - 1);
        chk("plast_py", 32'(pix_y), VA - 1);
        chk("plast_r", 32'(r), 2); chk("plast_g", 32'(g), 3); chk("plast_b", 32'(b), 3);
        wait_at(2, 11, 26);
        chk("after_de", 32'(de), 0); chk("after_px", 32'(pix_x), 0);

        // de and frame_start counts over one whole frame
        wait_at(3, 0, 0);
        de_n = 0; fs_n = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (i != 0) @(negedge clk);
            de_n += int'(de);
            fs_n += int'(frame_start);
        end
        chk("de_count", 32'(de_n), HA * VA);
        chk("fs_count", 32'(fs_n), 1);

        // Line 5 of frame 4 is one clock short
        wait_at(4, 6, 27); chk("short_pre", 32'(locked), 1);
        wait_at(4, 6, 28);
        chk("short_lock", 32'(locked), 0);
        chk("short_err", 32'(err_cnt), 1);
        chk("short_lmeas", 32'(line_meas), HT - 1);
        wait_at(4, 7, 28); chk("good_lmeas", 32'(line_meas), HT);
        wait_at(4, 14, 28); chk("short_acq", 32'(locked), 0);
        wait_at(5, 14, 27); chk("short_relock_pre", 32'(locked), 0);
        wait_at(5, 14, 28); chk("short_relock", 32'(locked), 1);
        chk("short_err2", 32'(err_cnt), 1);

        // hsync missing on lines 3..6 of frame 6 -> h_cnt hits 2*HT
        wait_at(6, 4, 28); chk("tmo_pre", 32'(locked), 1);
        wait_at(6, 4, 29);
        chk("tmo_lock", 32'(locked), 0);
        chk("tmo_err", 32'(err_cnt), 2);
        wait_at(6, 5, 10);
        chk("tmo_de", 32'(de), 0); chk("tmo_r", 32'(r), 0);
        chk("tmo_g", 32'(g), 0); chk("tmo_b", 32'(b), 0); chk("tmo_px", 32'(pix_x), 0);
        wait_at(7, 14, 27); chk("tmo_relock_pre", 32'(locked), 0);
        wait_at(7, 14, 28); chk("tmo_relock", 32'(locked), 1);
        chk("tmo_err2", 32'(err_cnt), 2);

        // Reset for 3 clocks mid-frame, then re-acquire from scratch
        wait_at(8, 8, 10); chk("mid_pre", 32'(locked), 1);
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk_all_zero("rstmid");
        rst_n = 1'b1;
        wait_at(8, 14, 28); chk("mid_acq", 32'(locked), 0);
        wait_at(9, 14, 27); chk("mid_relock_pre", 32'(locked), 0);
        wait_at(9, 14, 28);
        chk("mid_relock", 32'(locked), 1);
        chk("mid_err", 32'(err_cnt), 0);
        chk("mid_fmeas", 32'(frame_meas), VT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
